// File: rtl/fpu_wb_stage.sv
// FP writeback stage: merges ALU, FLW-load and long-latency results into the single
// FP regfile write port through an in-order completion queue, and accrues sticky fflags.
module fpu_wb_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lat_valid,
  input  logic [4:0]       lat_rd,
  input  logic [31:0]      lat_data,
  input  logic [4:0]       lat_fflags,
  input  logic             ld_valid,
  input  logic [4:0]       ld_rd,
  input  logic [31:0]      ld_data,
  input  logic             alu_valid,
  input  logic             alu_wb_en,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic [4:0]       alu_fflags,
  input  logic             fflags_clr,
  output logic             reg_write_f_en,
  output logic [4:0]       rd_temp_f_wb,
  output logic [31:0]      wb_data_f,
  output logic [4:0]       fflags,
  output logic             wb_ready,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  flags;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_en_q, wr_en_d;
  logic [4:0]         wr_rd_q, wr_rd_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [4:0]         fflags_q, fflags_d;
  logic               ovf_q, ovf_d;

  entry_t             src [3];
  logic [2:0]         src_v;
  entry_t             acc [3];
  logic [1:0]         n_acc;
  logic               pop;
  entry_t             wr_ent;
  int                 k0, n_push, n_free;

  always_comb begin
    src[0] = '{rd: lat_rd, data: lat_data, flags: lat_fflags};
    src[1] = '{rd: ld_rd,  data: ld_data,  flags: 5'd0};
    src[2] = '{rd: alu_rd, data: alu_data, flags: alu_fflags};
    src_v  = {alu_valid & alu_wb_en, ld_valid, lat_valid};

    // Compact accepted entries into age order: lat, ld, alu.
    acc[0] = '0;
    acc[1] = '0;
    acc[2] = '0;
    n_acc  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (src_v[i]) begin
        acc[n_acc] = src[i];
        n_acc      = n_acc + 2'd1;
      end
    end

    pop       = (count_q != '0);
    wr_en_d   = 1'b0;
    wr_ent    = '0;
    k0        = 0;
    if (pop) begin
      wr_en_d = 1'b1;
      wr_ent  = mem_q[rd_ptr_q];
    end else if (n_acc != 2'd0) begin
      wr_en_d = 1'b1;
      wr_ent  = acc[0];
      k0      = 1;
    end

    wr_rd_d   = wr_en_d ? wr_ent.rd   : wr_rd_q;
    wr_data_d = wr_en_d ? wr_ent.data : wr_data_q;

    // A slot freed by this edge's pop is reusable in the same edge.
    n_free = DEPTH - int'(count_q) + (pop ? 1 : 0);
    n_push = 0;
    mem_d  = mem_q;
    ovf_d  = ovf_q;
    for (int k = 0; k < 3; k++) begin
      if (k >= k0 && k < int'(n_acc)) begin
        if (n_push < n_free) begin
          mem_d[PTR_W'((int'(wr_ptr_q) + n_push) % DEPTH)] = acc[k];
          n_push = n_push + 1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    count_d  = CNT_W'(int'(count_q) + n_push - (pop ? 1 : 0));
    wr_ptr_d = PTR_W'((int'(wr_ptr_q) + n_push) % DEPTH);
    rd_ptr_d = pop ? PTR_W'((int'(rd_ptr_q) + 1) % DEPTH) : rd_ptr_q;

    fflags_d = fflags_clr ? 5'd0 : fflags_q;
    if (wr_en_d) fflags_d = fflags_d | wr_ent.flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      fflags_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      fflags_q  <= fflags_d;
      ovf_q     <= ovf_d;
    end
  end

  assign reg_write_f_en = wr_en_q;
  assign rd_temp_f_wb   = wr_rd_q;
  assign wb_data_f      = wr_data_q;
  assign fflags         = fflags_q;
  assign pending_cnt    = count_q;
  assign overflow_err   = ovf_q;
  assign wb_ready       = (DEPTH - int'(count_q)) >= 3;

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Bench for fpu_wb_stage: directed scenarios plus randomized traffic against a
// queue-based reference model of the writeback order, sticky flags and overflow.
module tb_fpu_wb_stage;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             lat_valid, ld_valid, alu_valid, alu_wb_en, fflags_clr;
  logic [4:0]       lat_rd, ld_rd, alu_rd, lat_fflags, alu_fflags;
  logic [31:0]      lat_data, ld_data, alu_data;
  logic             reg_write_f_en, wb_ready, overflow_err;
  logic [4:0]       rd_temp_f_wb, fflags;
  logic [31:0]      wb_data_f;
  logic [CNT_W-1:0] pending_cnt;

  always #5 clk = ~clk;

  fpu_wb_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .lat_valid(lat_valid), .lat_rd(lat_rd), .lat_data(lat_data), .lat_fflags(lat_fflags),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_wb_en(alu_wb_en), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_fflags(alu_fflags), .fflags_clr(fflags_clr),
    .reg_write_f_en(reg_write_f_en), .rd_temp_f_wb(rd_temp_f_wb), .wb_data_f(wb_data_f),
    .fflags(fflags), .wb_ready(wb_ready), .pending_cnt(pending_cnt), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  fl;
  } ent_t;

  ent_t        mq[$];
  logic        m_en, m_ovf;
  logic [4:0]  m_rd, m_ff;
  logic [31:0] m_data;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_ovf = 0; m_rd = 0; m_ff = 0; m_data = 0;
  endtask

  // Applies the writeback rules for one clock edge using the current inputs.
  task automatic model_edge();
    ent_t acc[$];
    ent_t e;
    if (lat_valid) acc.push_back('{lat_rd, lat_data, lat_fflags});
    if (ld_valid) acc.push_back('{ld_rd, ld_data, 5'd0});
    if (alu_valid && alu_wb_en) acc.push_back('{alu_rd, alu_data, alu_fflags});
    m_en = 0;
    e = '{5'd0, 32'd0, 5'd0};
    if (mq.size() > 0) begin
      e = mq.pop_front(); m_en = 1;
    end else if (acc.size() > 0) begin
      e = acc.pop_front(); m_en = 1;
    end
    foreach (acc[i]) begin
      if (mq.size() < DEPTH) mq.push_back(acc[i]);
      else m_ovf = 1;
    end
    if (fflags_clr) m_ff = 0;
    if (m_en) begin
      m_ff   = m_ff | e.fl;
      m_rd   = e.rd;
      m_data = e.data;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"}, 64'(reg_write_f_en), 64'(m_en));
    chk({tag, ".rd"}, 64'(rd_temp_f_wb), 64'(m_rd));
    chk({tag, ".data"}, 64'(wb_data_f), 64'(m_data));
    chk({tag, ".fflags"}, 64'(fflags), 64'(m_ff));
    chk({tag, ".pend"}, 64'(pending_cnt), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(wb_ready), 64'((DEPTH - mq.size()) >= 3));
    chk({tag, ".ovf"}, 64'(overflow_err), 64'(m_ovf));
  endtask

  task automatic idle();
    lat_valid = 0; ld_valid = 0; alu_valid = 0; alu_wb_en = 0; fflags_clr = 0;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic set_lat(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] f);
    lat_valid = 1; lat_rd = rd; lat_data = d; lat_fflags = f;
  endtask
  task automatic set_ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid = 1; ld_rd = rd; ld_data = d;
  endtask
  task automatic set_alu(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] f, input logic en);
    alu_valid = 1; alu_wb_en = en; alu_rd = rd; alu_data = d; alu_fflags = f;
  endtask

  task automatic set_triple(input int base);
    set_lat(5'(base), 32'h1000_0000 + 32'(base), 5'h10);
    set_ld(5'(base + 1), 32'h2000_0000 + 32'(base));
    set_alu(5'(base + 2), 32'h3000_0000 + 32'(base), 5'h01, 1'b1);
  endtask

  initial begin
    idle();
    lat_rd = 0; lat_data = 0; lat_fflags = 0; ld_rd = 0; ld_data = 0;
    alu_rd = 0; alu_data = 0; alu_fflags = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.en", 64'(reg_write_f_en), 64'd0);
    chk("rst.ready", 64'(wb_ready), 64'd1);
    chk("rst.pend", 64'(pending_cnt), 64'd0);
    check_all("rst");
    rst = 0;

    // Single ALU result into empty queue.
    set_alu(5'd3, 32'h3F80_0000, 5'h01, 1'b1);
    cycle("single");
    chk("single.en_c", 64'(reg_write_f_en), 64'd1);
    chk("single.rd_c", 64'(rd_temp_f_wb), 64'd3);
    chk("single.data_c", 64'(wb_data_f), 64'h3F80_0000);
    chk("single.ff_c", 64'(fflags), 64'h01);
    cycle("single_after");

    // Same-cycle triple drains in lat, ld, alu order.
    set_lat(5'd1, 32'h4000_0000, 5'h00);
    set_ld(5'd2, 32'h4040_0000);
    set_alu(5'd4, 32'h4080_0000, 5'h00, 1'b1);
    cycle("tri0");
    chk("tri0.rd_c", 64'(rd_temp_f_wb), 64'd1);
    chk("tri0.pend_c", 64'(pending_cnt), 64'd2);
    cycle("tri1");
    chk("tri1.rd_c", 64'(rd_temp_f_wb), 64'd2);
    chk("tri1.pend_c", 64'(pending_cnt), 64'd1);
    cycle("tri2");
    chk("tri2.rd_c", 64'(rd_temp_f_wb), 64'd4);
    chk("tri2.pend_c", 64'(pending_cnt), 64'd0);
    cycle("tri_idle");

    // ALU op that does not write the FP regfile.
    set_alu(5'd7, 32'hDEAD_BEEF, 5'h1F, 1'b0);
    cycle("nowb");
    chk("nowb.en_c", 64'(reg_write_f_en), 64'd0);

    // Fill and overflow: three triples back-to-back, then drain.
    set_triple(8);  cycle("fill0");
    chk("fill0.ready_c", 64'(wb_ready), 64'd0);
    set_triple(12); cycle("fill1");
    set_triple(16); cycle("fill2");
    chk("fill2.ovf_c", 64'(overflow_err), 64'd1);
    for (int i = 0; i < 6; i++) cycle("drain");

    // Clear coincident with a write replaces rather than accrues.
    fflags_clr = 1; cycle("clr_only");
    chk("clr_only.ff_c", 64'(fflags), 64'd0);
    set_lat(5'd5, 32'h1, 5'h10); cycle("ff10");
    set_alu(5'd6, 32'h2, 5'h04, 1'b1); fflags_clr = 1; cycle("clr_wr");
    chk("clr_wr.ff_c", 64'(fflags), 64'h04);
    cycle("clr_idle");

    // Asynchronous reset with entries pending.
    set_triple(20); cycle("prerst");
    set_triple(24); cycle("prerst2");
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst.en_c", 64'(reg_write_f_en), 64'd0);
    check_all("arst");
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) cycle("postrst");

    // Randomized traffic; occasionally ignore wb_ready to provoke drops.
    for (int i = 0; i < 400; i++) begin
      if (((DEPTH - mq.size()) >= 3) || ($urandom_range(0, 19) == 0)) begin
        if ($urandom_range(0, 2) == 0) set_lat(5'($urandom), $urandom, 5'($urandom));
        if ($urandom_range(0, 2) == 0) set_ld(5'($urandom), $urandom);
        if ($urandom_range(0, 1) == 0)
          set_alu(5'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      fflags_clr = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    for (int i = 0; i < 6; i++) cycle("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
